// File: rtl/ita_recip_divider.sv
// Bank of independent iterative dividers computing floor(2^DivShift / divisor) per lane.
// Define ITA_DIV_RADIX4_EN to retire two quotient bits per cycle instead of one.
module ita_recip_divider #(
    parameter int unsigned NumDiv   = 4,
    parameter int unsigned AccWidth = 32,
    parameter int unsigned OutWidth = 24,
    parameter int unsigned DivShift = 24
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [AccWidth-1:0]                div_inp_i,
    input  logic [NumDiv-1:0]                  div_valid_i,
    output logic [NumDiv-1:0]                  div_ready_o,
    output logic [NumDiv-1:0]                  div_valid_o,
    input  logic [NumDiv-1:0]                  div_ready_i,
    output logic [NumDiv-1:0][OutWidth-1:0]    div_oup_o,
    output logic                               idle_o
);

    localparam int unsigned NB = DivShift + 1;
`ifdef ITA_DIV_RADIX4_EN
    localparam int unsigned BitsPerIter = 2;
`else
    localparam int unsigned BitsPerIter = 1;
`endif
    localparam int unsigned Iters = (NB + BitsPerIter - 1) / BitsPerIter;
    localparam int unsigned CntW  = $clog2(Iters + 1);
    localparam int unsigned RemW  = AccWidth + 1;
    localparam int unsigned QW    = (NB > OutWidth) ? NB : OutWidth + 1;

    typedef enum logic [1:0] {
        Idle,
        Busy,
        Done
    } state_e;

    // The numerator is a single one at bit DivShift; any pad bit above NB-1 reads as zero.
    function automatic logic num_bit(input logic [31:0] idx);
        return idx == 32'(DivShift);
    endfunction

    // One restoring step: returns {new remainder, quotient bit}.
    function automatic logic [RemW:0] cond_sub(input logic [RemW-1:0]     rem,
                                               input logic [AccWidth-1:0] dvs,
                                               input logic                nbit);
        logic [RemW-1:0] sh;
        sh = {rem[AccWidth-1:0], nbit};
        if (sh >= {1'b0, dvs}) begin
            return {sh - {1'b0, dvs}, 1'b1};
        end
        return {sh, 1'b0};
    endfunction

    logic [NumDiv-1:0] lane_idle;

    for (genvar l = 0; l < NumDiv; l++) begin : g_lane
        state_e                 state_q, state_d;
        logic [CntW-1:0]        cnt_q, cnt_d;
        logic [AccWidth-1:0]    dvs_q, dvs_d;
        logic [RemW-1:0]        rem_q, rem_d;
        logic [NB-1:0]          quo_q, quo_d;
        logic [31:0]            hi_idx;
        logic [RemW:0]          st1;
        logic [RemW-1:0]        rem_nxt;
        logic [BitsPerIter-1:0] qbits;
        logic [QW-1:0]          quo_ext;
        logic                   sat;

        // Counter value c selects numerator bits BitsPerIter*c-1 downward.
        assign hi_idx = BitsPerIter * 32'(cnt_q) - 32'd1;
        assign st1    = cond_sub(rem_q, dvs_q, num_bit(hi_idx));
`ifdef ITA_DIV_RADIX4_EN
        logic [RemW:0] st2;
        assign st2     = cond_sub(st1[RemW:1], dvs_q, num_bit(hi_idx - 32'd1));
        assign rem_nxt = st2[RemW:1];
        assign qbits   = {st1[0], st2[0]};
`else
        assign rem_nxt = st1[RemW:1];
        assign qbits   = st1[0];
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            dvs_d   = dvs_q;
            rem_d   = rem_q;
            quo_d   = quo_q;
            unique case (state_q)
                Idle: begin
                    if (div_valid_i[l]) begin
                        dvs_d   = div_inp_i;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CntW'(Iters);
                        state_d = (div_inp_i == '0) ? Done : Busy;
                    end
                end
                Busy: begin
                    rem_d = rem_nxt;
                    quo_d = {quo_q[NB-BitsPerIter-1:0], qbits};
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = Done;
                    end
                end
                Done: begin
                    if (div_ready_i[l]) begin
                        state_d = Idle;
                    end
                end
                default: state_d = Idle;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= Idle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Datapath registers carry no reset; outputs are gated by the lane state.
        always_ff @(posedge clk_i) begin
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
        end

        assign quo_ext        = QW'(quo_q);
        assign sat            = (dvs_q == '0) || (quo_ext >= (QW'(1) << OutWidth));
        assign div_ready_o[l] = (state_q == Idle);
        assign div_valid_o[l] = (state_q == Done);
        assign lane_idle[l]   = (state_q == Idle);
        assign div_oup_o[l]   = (state_q != Done) ? '0 :
                                sat               ? '1 : quo_ext[OutWidth-1:0];
    end

    assign idle_o = &lane_idle;

endmodule

// File: tb/tb_ita_recip_divider.sv
// Directed and randomized bench for ita_recip_divider against an arithmetic reciprocal model.
// Honors ITA_DIV_RADIX4_EN for the expected latency.
module tb_ita_recip_divider;

    localparam int NumDiv   = 4;
    localparam int AccWidth = 32;
    localparam int OutWidth = 24;
    localparam int DivShift = 24;
    localparam int NB       = DivShift + 1;
`ifdef ITA_DIV_RADIX4_EN
    localparam int ITER = (NB + 1) / 2;
`else
    localparam int ITER = NB;
`endif

    logic                            clk_i;
    logic                            rst_ni;
    logic [AccWidth-1:0]             div_inp_i;
    logic [NumDiv-1:0]               div_valid_i;
    logic [NumDiv-1:0]               div_ready_o;
    logic [NumDiv-1:0]               div_valid_o;
    logic [NumDiv-1:0]               div_ready_i;
    logic [NumDiv-1:0][OutWidth-1:0] div_oup_o;
    logic                            idle_o;

    int total = 0;
    int bad   = 0;

    ita_recip_divider #(
        .NumDiv  (NumDiv),
        .AccWidth(AccWidth),
        .OutWidth(OutWidth),
        .DivShift(DivShift)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .div_inp_i  (div_inp_i),
        .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o),
        .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i),
        .div_oup_o  (div_oup_o),
        .idle_o     (idle_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] ref_q(input logic [31:0] d);
        longint unsigned q;
        if (d == 32'd0) return 64'hFF_FFFF;
        q = (64'd1 << DivShift) / {32'd0, d};
        if (q >= (64'd1 << OutWidth)) return 64'hFF_FFFF;
        return q;
    endfunction

    function automatic int ref_lat(input logic [31:0] d);
        return (d == 32'd0) ? 1 : ITER + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on a lane; result held hold extra cycles under backpressure.
    task automatic run_one(input int lane, input logic [31:0] d, input int hold);
        int n;
        check("ready_before_req", 64'(div_ready_o[lane]), 64'd1);
        div_inp_i          = d;
        div_valid_i[lane]  = 1'b1;
        div_ready_i[lane]  = (hold == 0);
        @(posedge clk_i); #1;
        div_valid_i[lane]  = 1'b0;
        div_inp_i          = $urandom;
        n = 1;
        while (!div_valid_o[lane] && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("latency", 64'(n), 64'(ref_lat(d)));
        check("quotient", 64'(div_oup_o[lane]), ref_q(d));
        check("ready_low_in_done", 64'(div_ready_o[lane]), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check("held_quotient", 64'(div_oup_o[lane]), ref_q(d));
            check("held_valid_ready", 64'({div_valid_o[lane], div_ready_o[lane]}), 64'b10);
        end
        div_ready_i[lane] = 1'b1;
        @(posedge clk_i); #1;
        check("back_to_idle", 64'({div_valid_o[lane], div_ready_o[lane]}), 64'b01);
        check("oup_zero_idle", 64'(div_oup_o[lane]), 64'd0);
    endtask

    initial begin
        int         seen[NumDiv];
        logic [23:0] val[NumDiv];
        int         idle_err;
        int         vld_cnt;
        int         lane;
        logic [31:0] d;

        rst_ni      = 1'b0;
        div_inp_i   = '0;
        div_valid_i = '0;
        div_ready_i = '1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 64'(div_ready_o), 64'hF);
        check("rst_valid", 64'(div_valid_o), 64'h0);
        check("rst_oup", 64'(div_oup_o), 64'h0);
        check("rst_idle", 64'(idle_o), 64'd1);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_ready", 64'(div_ready_o), 64'hF);

        // Directed values
        run_one(0, 32'd256, 0);
        run_one(1, 32'd3, 0);
        run_one(3, 32'h0100_0001, 0);
        run_one(0, 32'd1, 0);
        run_one(2, 32'd0, 0);
        run_one(1, 32'hFFFF_FFFF, 0);

        // Backpressure on lane 2
        run_one(2, 32'd16, 10);

        // All lanes accepted on consecutive cycles
        for (int l = 0; l < NumDiv; l++) seen[l] = -1;
        for (int l = 0; l < NumDiv; l++) begin
            div_inp_i   = 32'd2 << l;
            div_valid_i = 4'(1 << l);
            @(posedge clk_i); #1;
        end
        div_valid_i = '0;
        idle_err = 0;
        for (int t = NumDiv - 1; t < 80; t++) begin
            for (int l = 0; l < NumDiv; l++) begin
                if (div_valid_o[l] && seen[l] < 0) begin
                    seen[l] = t;
                    val[l]  = div_oup_o[l];
                end
            end
            if (seen[0] < 0 || seen[1] < 0 || seen[2] < 0 || seen[3] < 0 || div_valid_o != '0) begin
                if (idle_o !== 1'b0) idle_err++;
            end else begin
                break;
            end
            @(posedge clk_i); #1;
        end
        for (int l = 0; l < NumDiv; l++) begin
            check("multi_lat", 64'(seen[l]), 64'(l + ITER));
            check("multi_quot", 64'(val[l]), ref_q(32'd2 << l));
        end
        check("multi_idle_low", 64'(idle_err), 64'd0);
        check("multi_idle_high", 64'(idle_o), 64'd1);

        // Reset in the middle of a busy lane
        div_inp_i      = 32'd7;
        div_valid_i[1] = 1'b1;
        @(posedge clk_i); #1;
        div_valid_i[1] = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        check("busy_before_rst", 64'({idle_o, div_ready_o[1]}), 64'b00);
        rst_ni = 1'b0;
        #1;
        check("abort_ready", 64'(div_ready_o), 64'hF);
        check("abort_valid", 64'(div_valid_o), 64'h0);
        check("abort_oup", 64'(div_oup_o), 64'h0);
        check("abort_idle", 64'(idle_o), 64'd1);
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (div_valid_o != '0) vld_cnt++;
        end
        check("no_valid_after_abort", 64'(vld_cnt), 64'd0);
        run_one(1, 32'd7, 0);

        // Randomized divisors on random lanes
        for (int i = 0; i < 20; i++) begin
            lane = $urandom_range(0, NumDiv - 1);
            case ($urandom_range(0, 3))
                0:       d = $urandom_range(1, 1000);
                1:       d = $urandom;
                2:       d = $urandom >> $urandom_range(0, 31);
                default: d = 32'd1 << $urandom_range(0, 31);
            endcase
            run_one(lane, d, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ita_recip_divider.md
# ita_recip_divider

Bank of `NumDiv` independent iterative dividers. It is the responder side of the softmax division interface: it accepts accumulated exponent sums on per-lane valid/ready, computes the scaled reciprocal `floor(2^DivShift / sum)`, and holds each result on its lane until the initiator accepts it. It sits between the softmax unit's division FIFO and its accumulator write-back path.

## Interface
- `NumDiv`, default 4: number of divider lanes.
- `AccWidth`, default 32: divisor width, equal to `SoftmaxAccDataWidth`.
- `OutWidth`, default 24: quotient width, equal to `DividerWidth`.
- `DivShift`, default 24: the dividend is `2^DivShift`. Numerator bit count `NB = DivShift+1`.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `div_inp_i` input `AccWidth`: divisor, shared by all lanes.
- `div_valid_i` input `NumDiv`: per-lane request valid.
- `div_ready_o` output `NumDiv`: per-lane request ready.
- `div_valid_o` output `NumDiv`: per-lane result valid.
- `div_ready_i` input `NumDiv`: per-lane result ready.
- `div_oup_o` output `NumDiv x OutWidth`: per-lane quotient.
- `idle_o` output 1: all lanes are in IDLE.

## Operation
- Each lane runs its own 3-state FSM: IDLE, BUSY, DONE.
- **IDLE**
  - `div_ready_o[l]=1`.
  - On `div_valid_i[l] & div_ready_o[l]`:
    - Capture `div_inp_i`.
    - Clear remainder (`AccWidth+1` bits) and quotient (`NB` bits).
    - Load the iteration counter with the iteration count.
    - If the divisor is 0, go to DONE with the saturated result. Otherwise go to BUSY.
- **BUSY**
  - Restoring division, MSB first, over the `NB`-bit numerator `1<<DivShift`.
  - Each step: `rem = {rem, next_num_bit}`. If `rem >= divisor`, subtract the divisor and shift in quotient bit 1; else shift in 0.
  - When the counter reaches 0, go to DONE.
- **DONE**
  - `div_valid_o[l]=1`. `div_oup_o[l]` is held stable.
  - On `div_ready_i[l]`, go to IDLE.
  - `div_ready_o[l]` is 0 in DONE. A new request is never accepted in the same cycle a result is taken.
- **Saturation:** if the `NB`-bit quotient is greater than or equal to `2^OutWidth`, or the divisor is 0, the output is all ones. Otherwise the output is the low `OutWidth` bits.
- Lanes are fully independent. Any mix of simultaneous accepts and completions across lanes is legal.
- `div_oup_o[l]` is driven 0 whenever the lane is not in DONE.
- `div_valid_i[l]` asserted while the lane is BUSY or DONE is ignored (not captured). The initiator must hold it.
- **Reset values:**
  - `div_ready_o` all 1.
  - `div_valid_o` 0.
  - `div_oup_o` 0.
  - `idle_o` 1.
  - All FSMs in IDLE, counters 0.
- Reset asserted mid-operation aborts every lane immediately. Partial results are discarded and no `div_valid_o` pulse occurs.

## Timing
- Requests are accepted at the clock edge where valid and ready are both high.
- Radix-2: BUSY lasts `NB` cycles. `div_valid_o` rises `NB+1` cycles after the accept edge.
- Zero divisor: `div_valid_o` rises 1 cycle after the accept edge.
- Minimum per-lane turnaround:
  - `NB+2` cycles from accept to the next accept, when `div_ready_i` is held high.
  - The full-rate initiator rotates over the lanes to hide this latency.
- `div_ready_o` and `div_valid_o` are registered-state decodes only. There is no combinational path from `div_valid_i` or `div_ready_i` to any output.

## Configuration
- Macro `ITA_DIV_RADIX4_EN`.
- **Defined:** each BUSY cycle retires 2 quotient bits. Two conditional-subtract stages are cascaded.
  - Iterations = `ceil(NB/2)`.
  - For odd `NB`, the numerator is zero-extended by one MSB.
  - Valid rises `ceil(NB/2)+1` cycles after accept.
- **Undefined:** radix-2, `NB` iterations.
- Results are bit-identical in both modes.

## Test plan
All scenarios use default parameters: `NB=25`. The 2^24/256 result of scenario 1 is bit-identical in radix-4 mode.
- **Single request:** lane 0, divisor 256, `div_ready_i=1`.
  - `div_oup_o[0]=0x010000`, valid exactly 26 cycles after accept.
  - With `ITA_DIV_RADIX4_EN`: valid after 14 cycles.
- **Rounding:** divisor 3 -> 5592405 (0x555555). Divisor 0x01000001 -> 0.
- **Saturation:** divisor 1 -> 0xFFFFFF. Divisor 0 -> 0xFFFFFF, with valid 1 cycle after accept.
- **Backpressure:** lane 2, divisor 16, `div_ready_i[2]=0` for 10 cycles after valid.
  - Result held at 0x100000, `div_ready_o[2]=0` throughout.
  - Lane returns to IDLE one cycle after ready.
- **All lanes:** accept on lanes 0..3 on consecutive cycles with divisors 2, 4, 8, 16.
  - Results 0x800000, 0x400000, 0x200000, 0x100000 appear on consecutive cycles.
  - `idle_o=0` until the last result is taken.
- **Reset:** assert `rst_ni` low at iteration 10 of a BUSY lane.
  - All outputs return to their reset values.
  - No valid pulse. The next request completes correctly.
